// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the simplified MIPS core.
//   - Primary opcode constants (instr[31:26]) decoded by main_control.
//   - NOP_WORD: the bubble instruction (sll $0,$0,0).
//   - fetch_state_t: states of the instruction-fetch sequencer.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,  // first cycle after reset, no request yet
    S_REQ     = 2'd1,  // request outstanding at pc
    S_HOLD    = 2'd2,  // word parked in skid while downstream stalls
    S_DISCARD = 2'd3   // stale request after a redirect, result dropped
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with synchronous active-high reset, load-enable
// for sequential advance, and redirect mux (redirect has priority).
// The PC is always word aligned; low two bits are forced to zero.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   load_en           advance pc by 4 this cycle
//   redirect          load target (aligned) this cycle, overrides load_en
//   target            redirect address
//   pc                current PC
//   pc_plus4          pc + 4, modulo 2^PC_WIDTH
module pc_reg #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_en,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] FOUR       = PC_WIDTH'(4);

  // Natural wrap of the adder gives the modulo-2^PC_WIDTH behaviour.
  assign pc_plus4 = pc + FOUR;

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset)         pc <= RESET_PC & ALIGN_MASK;
    else if (redirect) pc <= target & ALIGN_MASK;
    else if (load_en)  pc <= pc_plus4;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage. Holds the PC (pc_reg), fetches
// words over a req/ack handshake and loads the IF/ID pipeline register.
// Handles load-use stalls (skid register), beq redirects (flush + discard
// of any in-flight request) and bubbles while memory is slow.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   stall                        hazard unit: hold IF/ID and PC
//   branch_taken, branch_target  redirect from beq resolution
//   imem_req, imem_addr          fetch request, address stable while req=1
//   imem_ack, imem_rdata         completion strobe and fetched word
//   if_id_instr/pc4/valid        IF/ID pipeline register
//   op                           if_id_instr[31:26] for main_control
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_bubbles
// saturating counters of valid loads and bubble loads.
module if_fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc4,
  output logic                if_id_valid,
  output logic [5:0]          op
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles
`endif
);

  import mips_pkg::*;

  fetch_state_t        state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_plus4, old_addr;
  logic [31:0]         skid;
  logic                pc_inc, ld_word, ld_skid, ld_bubble, cap_skid;

  pc_reg #(
    .PC_WIDTH(PC_WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load_en  (pc_inc),
    .redirect (branch_taken),
    .target   (branch_target),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign op = if_id_instr[31:26];

  // A request abandoned by a redirect must finish at the address it was
  // issued with, while pc already points at the branch target.
  assign imem_addr = (state == S_DISCARD) ? old_addr : pc;

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    pc_inc    = 1'b0;
    ld_word   = 1'b0;
    ld_skid   = 1'b0;
    ld_bubble = 1'b0;
    cap_skid  = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          // An acked word is simply dropped; otherwise the request is still
          // in flight and must be drained.
          state_nxt = imem_ack ? S_REQ : S_DISCARD;
        end else if (imem_ack && stall) begin
          cap_skid  = 1'b1;
          state_nxt = S_HOLD;
        end else if (imem_ack) begin
          ld_word = 1'b1;
          pc_inc  = 1'b1;
        end else if (!stall) begin
          ld_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          state_nxt = S_REQ;
        end else if (!stall) begin
          ld_skid   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        imem_req  = 1'b1;
        ld_bubble = 1'b1;
        if (imem_ack) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Redirect flushes IF/ID in every state, overriding any stall hold.
    if (branch_taken) ld_bubble = 1'b1;
  end

  // NOTE: the skid word and old_addr are reset too, so the stage never
  // exposes an X-valued word even on paths that should not read them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      skid        <= NOP_WORD;
      old_addr    <= '0;
    end else begin
      state <= state_nxt;
      if (ld_bubble) begin
        if_id_instr <= NOP_WORD;
        if_id_pc4   <= '0;
        if_id_valid <= 1'b0;
      end else if (ld_word) begin
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
      end else if (ld_skid) begin
        if_id_instr <= skid;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
      end
      if (branch_taken)  skid <= NOP_WORD;
      else if (cap_skid) skid <= imem_rdata;
      if (state == S_REQ && branch_taken && !imem_ack) old_addr <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if ((ld_word || ld_skid) && !ld_bubble && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (ld_bubble && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
